dds_wave_ctrl: RTL and testbench
================================

DDS_WAVE_CTRL -- requirements
Module: dds_wave_ctrl

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, phase-accumulator width (minimum 12).
REQ-002 SHALL have parameter ROM_AW, default 10, ROM address width taken from phase MSBs.
REQ-003 SHALL have port clk_125M, input, 1, sole clock (DAC sample clock); all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, level; 1 = generate, 0 = idle at midscale.
REQ-006 SHALL have port cfg_valid, input, 1, config offer.
REQ-007 SHALL have port cfg_ready, output, 1, config accept.
REQ-008 SHALL have port cfg_ftw, input, PHASE_W, frequency tuning word.
REQ-009 SHALL have port cfg_wave_sel, input, 2: 0 = ROM table, 1 = square, 2 = sawtooth, 3 = triangle.
REQ-010 SHALL have port cfg_amp, input, 8, amplitude scale (0 = flat midscale).
REQ-011 SHALL have port rom_addr, output, ROM_AW, registered address to the external wave ROM (ROM read latency: 1 cycle).
REQ-012 SHALL have port rom_data, input, 8, ROM read data.
REQ-013 SHALL have port da_data, output, 8, offset-binary DAC sample, registered.
REQ-014 SHALL have port da_valid, output, 1, high when da_data carries a generated sample.

Function
REQ-015 SHALL implement states IDLE, FILL and RUN.
REQ-016 IDLE -> FILL when enable = 1; FILL -> RUN after exactly 3 cycles; any state -> IDLE in the cycle after enable = 0.
REQ-017 In IDLE: phase = 0, rom_addr = 0, da_data = 8'd128, da_valid = 0.
REQ-018 In FILL/RUN: phase <= phase + active_ftw every cycle, modulo 2^PHASE_W.
REQ-019 rom_addr SHALL equal phase[PHASE_W-1 -: ROM_AW], registered with phase.
REQ-020 Raw sample (aligned with rom_data, one cycle after phase), with p = phase delayed 1 cycle: sel 0 = rom_data; sel 1 = p[MSB] ? 0 : 255; sel 2 = p[MSB -: 8]; sel 3 = p[MSB] ? ~p[MSB-1 -: 8] : p[MSB-1 -: 8].
REQ-021 Scaling: s = raw - 128 (9-bit signed); da_data = 128 + ((s * cfg_amp) >>> 8), arithmetic shift (floor), result always within 0..254.
REQ-022 Raw sample SHALL be registered before the multiply, giving 3 cycles of latency from a phase update to the da_data update; da_valid rises on the first FILL->RUN cycle.
REQ-023 A config transfer SHALL occur when cfg_valid & cfg_ready; ftw, wave_sel and amp are captured into a shadow set and the pending flag is set.
REQ-024 cfg_ready SHALL be 0 while the pending flag is set, otherwise 1.
REQ-025 In IDLE, a pending shadow set SHALL become active on the next cycle.
REQ-026 In FILL/RUN, a pending shadow set SHALL become active only in the cycle after a phase-accumulator carry-out (wrap), so no waveform period is truncated.
REQ-027 A transfer in the same cycle as a wrap SHALL apply at the following wrap.
REQ-028 A pending set with active_ftw = 0 SHALL apply only on return to IDLE.
REQ-029 Wave_sel and amp changes SHALL propagate through the pipeline in step with the phase, with no mixed-config sample.
REQ-030 Deasserting enable mid-period SHALL discard in-flight samples; da_valid falls and da_data = 128 on the next cycle.

Reset
REQ-031 While rst_n = 0: state = IDLE, phase = 0, rom_addr = 0, da_data = 8'd128, da_valid = 0, cfg_ready = 1, pending = 0.
REQ-032 While rst_n = 0, the active set SHALL be ftw = 0x0040_0000 (PHASE_W = 32), wave_sel = 0, amp = 255.
REQ-033 Reset assertion SHALL take effect immediately; release SHALL be synchronous to clk_125M through the existing lock-derived rst_n.

Verification
REQ-034 Reset release, enable = 1, defaults: rom_addr steps 0,1,2,... once per cycle, wrapping 1023 -> 0 (1024-cycle period, 122.07 kHz); first da_valid 3 cycles after FILL entry.
REQ-035 wave_sel = 1, amp = 255, ftw = 0x0200_0000: da_data alternates 254 for 64 cycles, then 0 for 64 cycles.
REQ-036 amp = 0, any waveform: da_data = 128 constantly while da_valid = 1.
REQ-037 Config offered mid-period in RUN: cfg_ready drops the next cycle; new ftw is first applied in the cycle after the wrap; cfg_ready returns to 1 that cycle.
REQ-038 enable dropped mid-RUN: next cycle da_valid = 0, da_data = 128, rom_addr = 0; re-enable restarts from phase 0 with a 3-cycle fill.
REQ-039 rst_n pulsed low for 2 ns mid-RUN with a pending config: all outputs take reset values immediately, and the pending config is lost.

Source files
------------

// File: rtl/dds_wave_ctrl.sv
// DDS waveform controller: phase accumulator, four wave sources,
// amplitude scaling and config updates aligned to phase wraps.
module dds_wave_ctrl #(
  parameter int PHASE_W = 32,
  parameter int ROM_AW  = 10
) (
  input  logic               clk_125M,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [1:0]         cfg_wave_sel,
  input  logic [7:0]         cfg_amp,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [7:0]         rom_data,
  output logic [7:0]         da_data,
  output logic               da_valid
);

  localparam logic [PHASE_W-1:0] FTW_RST =
    PHASE_W'(1) << (PHASE_W - 10);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  state_t             state_q;
  logic [1:0]         fill_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               carry;
  logic [PHASE_W:0]   acc_sum;

  logic [PHASE_W-1:0] ftw_q;
  logic [1:0]         sel_q;
  logic [7:0]         amp_q;
  logic [PHASE_W-1:0] sh_ftw_q;
  logic [1:0]         sh_sel_q;
  logic [7:0]         sh_amp_q;
  logic               pend_q;
  logic               apply;
  logic               xfer;

  logic [8:0]         ph1_q;
  logic [1:0]         sel1_q;
  logic [7:0]         amp1_q;
  logic [7:0]         raw_d;
  logic [7:0]         raw_q;
  logic [7:0]         amp2_q;

  logic signed [17:0] smp_s;
  logic signed [17:0] amp_s;
  logic signed [17:0] prod;
  logic [7:0]         da_calc;
  logic [7:0]         da_q;
  logic               dv_q;

  assign acc_sum = {1'b0, phase_q} + {1'b0, ftw_q};
  assign phase_d = acc_sum[PHASE_W-1:0];
  assign carry   = acc_sum[PHASE_W];

  // Running configs only change on a wrap so periods stay whole
  assign xfer  = cfg_valid & ~pend_q;
  assign apply = pend_q &
                 ((state_q == IDLE) | (enable & carry));

  always_comb begin
    raw_d = rom_data;
    unique case (sel1_q)
      2'd0: raw_d = rom_data;
      2'd1: raw_d = ph1_q[8] ? 8'd0 : 8'd255;
      2'd2: raw_d = ph1_q[8:1];
      2'd3: raw_d = ph1_q[8] ? ~ph1_q[7:0] : ph1_q[7:0];
    endcase
  end

  assign smp_s   = {10'd0, raw_q} - 18'd128;
  assign amp_s   = {10'd0, amp2_q};
  assign prod    = smp_s * amp_s;
  assign da_calc = 8'((prod >>> 8) + 18'sd128);

  always_ff @(posedge clk_125M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fill_q   <= '0;
      phase_q  <= '0;
      da_q     <= 8'd128;
      dv_q     <= 1'b0;
      pend_q   <= 1'b0;
      ftw_q    <= FTW_RST;
      sel_q    <= 2'd0;
      amp_q    <= 8'd255;
      sh_ftw_q <= '0;
      sh_sel_q <= 2'd0;
      sh_amp_q <= 8'd0;
    end else begin
      if (apply) begin
        ftw_q  <= sh_ftw_q;
        sel_q  <= sh_sel_q;
        amp_q  <= sh_amp_q;
        pend_q <= 1'b0;
      end else if (xfer) begin
        sh_ftw_q <= cfg_ftw;
        sh_sel_q <= cfg_wave_sel;
        sh_amp_q <= cfg_amp;
        pend_q   <= 1'b1;
      end
      if (!enable) begin
        state_q <= IDLE;
        phase_q <= '0;
        da_q    <= 8'd128;
        dv_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= FILL;
            fill_q  <= '0;
          end
          FILL: begin
            phase_q <= phase_d;
            fill_q  <= fill_q + 2'd1;
            if (fill_q == 2'd2) begin
              state_q <= RUN;
              dv_q    <= 1'b1;
              da_q    <= da_calc;
            end
          end
          RUN: begin
            phase_q <= phase_d;
            da_q    <= da_calc;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Config travels with its phase so no sample mixes two sets
  always_ff @(posedge clk_125M or negedge rst_n) begin
    if (!rst_n) begin
      ph1_q  <= '0;
      sel1_q <= 2'd0;
      amp1_q <= 8'd0;
      raw_q  <= 8'd0;
      amp2_q <= 8'd0;
    end else begin
      ph1_q  <= phase_q[PHASE_W-1 -: 9];
      sel1_q <= sel_q;
      amp1_q <= amp_q;
      raw_q  <= raw_d;
      amp2_q <= amp1_q;
    end
  end

  assign cfg_ready = ~pend_q;
  assign rom_addr  = phase_q[PHASE_W-1 -: ROM_AW];
  assign da_data   = da_q;
  assign da_valid  = dv_q;

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Bench for dds_wave_ctrl: cycle model of the DDS rules plus
// directed literal checks on fill, wraps, config timing, reset.
module tb_dds_wave_ctrl;

  logic        clk_125M = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_ftw;
  logic [1:0]  cfg_wave_sel;
  logic [7:0]  cfg_amp;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [7:0]  da_data;
  logic        da_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rom_mem [1024];

  dds_wave_ctrl #(.PHASE_W(32), .ROM_AW(10)) dut (
    .clk_125M    (clk_125M),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ftw     (cfg_ftw),
    .cfg_wave_sel(cfg_wave_sel),
    .cfg_amp     (cfg_amp),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .da_data     (da_data),
    .da_valid    (da_valid)
  );

  always #4 clk_125M = ~clk_125M;

  always @(posedge clk_125M) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on phase and configs
  logic [31:0] m_ph   = 32'd0;
  logic [31:0] m_ftw  = 32'h0040_0000;
  int          m_sel  = 0;
  int          m_amp  = 255;
  logic [31:0] s_ftw  = 32'd0;
  int          s_sel  = 0;
  int          s_amp  = 0;
  bit          m_pend = 1'b0;
  int          m_cyc  = -1;
  logic [31:0] q_ph[$];
  int          q_sel[$];
  int          q_amp[$];

  function automatic int f_raw(logic [31:0] ph, int sel);
    case (sel)
      0: return int'(rom_mem[ph[31:22]]);
      1: return ph[31] ? 0 : 255;
      2: return int'(ph[31:24]);
      default: return ph[31] ? 255 - int'(ph[30:23])
                             : int'(ph[30:23]);
    endcase
  endfunction

  function automatic int f_scale(int raw, int amp);
    int s;
    int p;
    int q;
    s = raw - 128;
    p = s * amp;
    if (p >= 0) q = p / 256;
    else q = -((-p + 255) / 256);
    return 128 + q;
  endfunction

  function automatic int exp_da();
    if (m_cyc >= 3 && q_ph.size() == 4)
      return f_scale(f_raw(q_ph[0], q_sel[0]), q_amp[0]);
    return 128;
  endfunction

  initial begin
    forever begin
      @(posedge clk_125M or negedge rst_n);
      if (!rst_n) begin
        m_ph = 32'd0; m_ftw = 32'h0040_0000;
        m_sel = 0; m_amp = 255; m_pend = 1'b0;
        m_cyc = -1;
        q_ph.delete(); q_sel.delete(); q_amp.delete();
      end else begin
        longint tot;
        bit carry;
        bit xfer;
        bit apply;
        tot   = longint'(m_ph) + longint'(m_ftw);
        carry = tot >= 64'sh1_0000_0000;
        xfer  = cfg_valid && !m_pend;
        apply = m_pend && (m_cyc < 0 || (enable && carry));
        if (apply) begin
          m_ftw = s_ftw; m_sel = s_sel; m_amp = s_amp;
          m_pend = 1'b0;
        end else if (xfer) begin
          s_ftw = cfg_ftw; s_sel = int'(cfg_wave_sel);
          s_amp = int'(cfg_amp); m_pend = 1'b1;
        end
        if (!enable) begin
          m_cyc = -1; m_ph = 32'd0;
        end else if (m_cyc < 0) begin
          m_cyc = 0; m_ph = 32'd0;
        end else begin
          m_cyc++;
          m_ph = tot[31:0];
        end
        q_ph.push_back(m_ph);
        q_sel.push_back(m_sel);
        q_amp.push_back(m_amp);
        if (q_ph.size() > 4) begin
          void'(q_ph.pop_front());
          void'(q_sel.pop_front());
          void'(q_amp.pop_front());
        end
      end
    end
  end

  always @(negedge clk_125M) begin
    chk("da_valid", int'(da_valid), (m_cyc >= 3) ? 1 : 0);
    chk("da_data", int'(da_data), exp_da());
    chk("rom_addr", int'(rom_addr), int'(m_ph[31:22]));
    chk("cfg_ready", int'(cfg_ready), m_pend ? 0 : 1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_125M);
  endtask

  task automatic offer(input logic [31:0] f, input int s,
                       input int a);
    cfg_ftw      = f;
    cfg_wave_sel = 2'(s);
    cfg_amp      = 8'(a);
    cfg_valid    = 1'b1;
    tick(1);
    cfg_valid    = 1'b0;
    chk("ready_drop", int'(cfg_ready), 0);
  endtask

  task automatic wait_wrap();
    int k;
    k = 0;
    while (rom_addr != 10'd0 && k < 3000) begin
      tick(1);
      k++;
    end
    chk("wrap_seen", int'(rom_addr), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'((i * 7 + 3) & 255);
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_ftw = 32'd0; cfg_wave_sel = 2'd0; cfg_amp = 8'd0;
    tick(3);
    chk("rst_da", int'(da_data), 128);
    chk("rst_dv", int'(da_valid), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;
    tick(1);
    enable = 1'b1;
    tick(1);
    chk("fill_addr0", int'(rom_addr), 0);
    chk("fill_dv0", int'(da_valid), 0);
    tick(1);
    chk("fill_addr1", int'(rom_addr), 1);
    tick(1);
    chk("fill_dv2", int'(da_valid), 0);
    tick(1);
    chk("first_dv", int'(da_valid), 1);
    chk("first_da", int'(da_data), 3);
    chk("first_addr", int'(rom_addr), 3);
    tick(1020);
    chk("addr_1023", int'(rom_addr), 1023);
    tick(1);
    chk("addr_wrap", int'(rom_addr), 0);
    tick(100);
    offer(32'h0200_0000, 1, 255);
    wait_wrap();
    chk("ready_back", int'(cfg_ready), 1);
    tick(1);
    chk("new_ftw_step", int'(rom_addr), 8);
    tick(2);
    chk("sq_hi_first", int'(da_data), 254);
    tick(63);
    chk("sq_hi_last", int'(da_data), 254);
    tick(1);
    chk("sq_lo_first", int'(da_data), 0);
    tick(63);
    chk("sq_lo_last", int'(da_data), 0);
    tick(1);
    chk("sq_hi_again", int'(da_data), 254);
    offer(32'h0200_0000, 2, 0);
    wait_wrap();
    tick(5);
    chk("amp0_da", int'(da_data), 128);
    chk("amp0_dv", int'(da_valid), 1);
    tick(20);
    offer(32'h0100_0000, 3, 200);
    wait_wrap();
    tick(3);
    chk("tri_start", int'(da_data), 28);
    tick(64);
    chk("tri_mid", int'(da_data), 128);
    tick(128);
    chk("tri_floor", int'(da_data), 127);
    offer(32'h0040_0000, 0, 100);
    wait_wrap();
    tick(3);
    chk("rom_amp100", int'(da_data), 79);
    tick(50);
    offer(32'h0000_0000, 2, 255);
    wait_wrap();
    chk("ftw0_ready", int'(cfg_ready), 1);
    offer(32'h0200_0000, 1, 255);
    tick(300);
    chk("ftw0_hold", int'(cfg_ready), 0);
    chk("ftw0_addr", int'(rom_addr), 0);
    chk("ftw0_da", int'(da_data), 0);
    enable = 1'b0;
    tick(1);
    chk("off_dv", int'(da_valid), 0);
    chk("off_da", int'(da_data), 128);
    chk("off_addr", int'(rom_addr), 0);
    chk("off_ready", int'(cfg_ready), 0);
    tick(1);
    chk("idle_apply", int'(cfg_ready), 1);
    enable = 1'b1;
    tick(1);
    chk("re_addr0", int'(rom_addr), 0);
    chk("re_dv0", int'(da_valid), 0);
    tick(1);
    chk("re_addr1", int'(rom_addr), 8);
    tick(2);
    chk("re_dv", int'(da_valid), 1);
    chk("re_da", int'(da_data), 254);
    tick(40);
    offer(32'h0100_0000, 3, 50);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_da", int'(da_data), 128);
    chk("pulse_dv", int'(da_valid), 0);
    chk("pulse_addr", int'(rom_addr), 0);
    chk("pulse_ready", int'(cfg_ready), 1);
    #1 rst_n = 1'b1;
    tick(1);
    chk("post_addr0", int'(rom_addr), 0);
    chk("post_ready", int'(cfg_ready), 1);
    tick(1);
    chk("post_addr1", int'(rom_addr), 1);
    tick(2);
    chk("post_dv", int'(da_valid), 1);
    chk("post_da", int'(da_data), 3);
    tick(30);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
